regfile_write_arbiter: RTL and testbench

// - Arbitrates the single register file write port between N writeback

---
 rtl/regfile_write_arbiter_pkg.sv | 20 ++
 rtl/regfile_write_arbiter_rr.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register file write arbiter and its
// pending-write scoreboard.
package PkgRegFileArbiter;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 2;

  typedef logic [3:0]                RegSel;
  typedef logic [DEF_DATA_WIDTH-1:0] RegData;
  typedef logic [DEF_CNT_WIDTH-1:0]  PendCnt;

  typedef struct packed {
    logic   valid;
    RegSel  sel;
    RegData data;
  } PortIn_WbReq;

  localparam RegSel ZERO_REG = 4'd0;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Round-robin grant over the writeback sources; the pointer moves just past
// the last winner so every requester is served within NUM_SOURCES grants.
module round_robin_arbiter #(
  parameter int NUM_SOURCES = 3,
  parameter int PW          = $clog2(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] req,
  output logic [NUM_SOURCES-1:0] grant,
  output logic [PW-1:0]          grant_idx,
  output logic                   grant_any
);

  logic [PW-1:0] rr_ptr;

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int off = 0; off < NUM_SOURCES; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_SOURCES;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
    // Nothing may be granted while reset is held, or the handshake would complete.
    if (!reset_n) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == PW'(NUM_SOURCES - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write port arbiter with a registered write output and a
// per-register pending-write scoreboard that drives decode RAW hazard flags.
module regfile_write_arbiter
  import PkgRegFileArbiter::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int NUM_REGS    = 16,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SOURCES-1:0]            req_valid,
  input  logic [NUM_SOURCES*4-1:0]          req_sel,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] req_data,
  output logic [NUM_SOURCES-1:0]            req_ready,
  output logic                              wr_en,
  output logic [3:0]                        wr_sel,
  output logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rsv_en,
  input  logic [3:0]                        rsv_sel,
  output logic                              rsv_ready,
  input  logic [3:0]                        query_sel_ra,
  input  logic [3:0]                        query_sel_rb,
  input  logic [3:0]                        query_sel_rc,
  output logic                              hazard_ra,
  output logic                              hazard_rb,
  output logic                              hazard_rc,
  output logic                              err_underflow
);

  localparam int PW = $clog2(NUM_SOURCES);

  PortIn_WbReq            reqs [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] req_vec;
  logic [NUM_SOURCES-1:0] grant;
  logic [PW-1:0]          grant_idx;
  logic                   grant_any;
  PortIn_WbReq            acc;
  logic                   retire;
  logic                   reserve;
  logic [NUM_REGS-1:0]    inc_vec;
  logic [NUM_REGS-1:0]    dec_vec;
  logic [CNT_WIDTH-1:0]   count [NUM_REGS];

  always_comb begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      reqs[s].valid = req_valid[s];
      reqs[s].sel   = req_sel[s*4 +: 4];
      reqs[s].data  = req_data[s*DATA_WIDTH +: DATA_WIDTH];
      req_vec[s]    = reqs[s].valid;
    end
  end

  round_robin_arbiter #(.NUM_SOURCES(NUM_SOURCES), .PW(PW)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_vec),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign acc       = reqs[grant_idx];
  assign retire    = grant_any && (acc.sel != ZERO_REG);
  assign rsv_ready = reset_n && (count[rsv_sel] != {CNT_WIDTH{1'b1}});
  assign reserve   = rsv_en && rsv_ready && (rsv_sel != ZERO_REG);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (reserve) inc_vec[rsv_sel] = 1'b1;
    if (retire)  dec_vec[acc.sel] = 1'b1;
  end

  // A write to r0 still completes the handshake but never reaches the register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else if (grant_any) begin
      wr_en   <= (acc.sel != ZERO_REG);
      wr_sel  <= acc.sel;
      wr_data <= acc.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Reserve and retire of the same register cancel; a lone retire at zero is an error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      count[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          count[r] <= count[r] + CNT_WIDTH'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (count[r] == '0) err_underflow <= 1'b1;
          else                count[r]      <= count[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign hazard_ra = (query_sel_ra != ZERO_REG) && (count[query_sel_ra] != '0);
  assign hazard_rb = (query_sel_rb != ZERO_REG) && (count[query_sel_rb] != '0);
  assign hazard_rc = (query_sel_rc != ZERO_REG) && (count[query_sel_rc] != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [11:0] req_sel;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_sel;
  logic        rsv_ready;
  logic [3:0]  query_sel_ra, query_sel_rb, query_sel_rc;
  logic        hazard_ra, hazard_rb, hazard_rc;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_sel       (req_sel),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_data       (wr_data),
    .rsv_en        (rsv_en),
    .rsv_sel       (rsv_sel),
    .rsv_ready     (rsv_ready),
    .query_sel_ra  (query_sel_ra),
    .query_sel_rb  (query_sel_rb),
    .query_sel_rc  (query_sel_rc),
    .hazard_ra     (hazard_ra),
    .hazard_rb     (hazard_rb),
    .hazard_rc     (hazard_rc),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int src, input logic v, input logic [3:0] sel, input logic [31:0] data);
    req_valid[src]         = v;
    req_sel[src*4 +: 4]    = sel;
    req_data[src*32 +: 32] = data;
  endtask

  task automatic reserveReg(input logic [3:0] r);
    rsv_en  = 1'b1;
    rsv_sel = r;
    tick();
    rsv_en  = 1'b0;
  endtask

  logic [2:0]  exp_grant [6];
  logic [3:0]  src_reg   [3];
  logic [31:0] src_val   [3];

  initial begin
    reset_n = 1'b0; req_valid = '0; req_sel = '0; req_data = '0;
    rsv_en = 1'b0; rsv_sel = '0;
    query_sel_ra = '0; query_sel_rb = '0; query_sel_rc = '0;
    exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    src_reg   = '{4'd1, 4'd2, 4'd4};
    src_val   = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0004};

    // Reset state, with requests pending that must not be accepted
    tick(); tick();
    req_valid = 3'b111;
    rsv_sel   = 4'd3;
    #1;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_sel", wr_sel, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_err", err_underflow, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsv_ready", rsv_ready, 0);
    req_valid = '0;
    reset_n   = 1'b1;
    tick();
    checkOutput("post_rst_rsv_ready", rsv_ready, 1);

    // Single request r3 <= DEADBEEF from the ALU, reserved first
    reserveReg(4'd3);
    query_sel_ra = 4'd3;
    #1;
    checkOutput("r3_hazard_set", hazard_ra, 1);
    applyStimulus(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    #1;
    checkOutput("single_ready", req_ready, 3'b001);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("single_wr_en", wr_en, 1);
    checkOutput("single_wr_sel", wr_sel, 3);
    checkOutput("single_wr_data", wr_data, 32'hDEAD_BEEF);
    checkOutput("r3_hazard_clear", hazard_ra, 0);
    tick();
    checkOutput("idle_wr_en", wr_en, 0);
    checkOutput("idle_wr_sel_hold", wr_sel, 3);
    checkOutput("idle_wr_data_hold", wr_data, 32'hDEAD_BEEF);

    // Zero register from source 2 (pointer currently at 1) moves pointer to 0
    applyStimulus(2, 1'b1, 4'd0, 32'h1234);
    query_sel_rb = 4'd0;
    #1;
    checkOutput("zero_ready", req_ready, 3'b100);
    tick();
    applyStimulus(2, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("zero_wr_en", wr_en, 0);
    checkOutput("zero_hazard", hazard_rb, 0);
    checkOutput("zero_no_err", err_underflow, 0);

    // Contention: r1, r2, r4 each reserved twice, all sources stay valid
    for (int i = 0; i < 3; i++) begin
      reserveReg(src_reg[i]);
      reserveReg(src_reg[i]);
    end
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, src_reg[i], src_val[i]);
    query_sel_ra = 4'd1; query_sel_rb = 4'd2; query_sel_rc = 4'd4;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("cont_grant_%0d", c), req_ready, exp_grant[c]);
      tick();
      checkOutput($sformatf("cont_wr_sel_%0d", c), wr_sel, src_reg[c % 3]);
      checkOutput($sformatf("cont_wr_data_%0d", c), wr_data, src_val[c % 3]);
      checkOutput($sformatf("cont_wr_en_%0d", c), wr_en, 1);
      if (c == 2) begin
        checkOutput("cont_mid_hazard", {hazard_ra, hazard_rb, hazard_rc}, 3'b111);
      end
    end
    req_valid = '0;
    #1;
    checkOutput("cont_end_hazard", {hazard_ra, hazard_rb, hazard_rc}, 3'b000);

    // Scoreboard: r5 reserved twice, retired twice through source 1
    reserveReg(4'd5);
    reserveReg(4'd5);
    query_sel_ra = 4'd5;
    #1;
    checkOutput("r5_hazard_2", hazard_ra, 1);
    applyStimulus(1, 1'b1, 4'd5, 32'h5555_0001);
    tick();
    checkOutput("r5_hazard_1", hazard_ra, 1);
    applyStimulus(1, 1'b1, 4'd5, 32'h5555_0002);
    #1;
    checkOutput("r5_second_ready", req_ready, 3'b010);
    tick();
    applyStimulus(1, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("r5_hazard_0", hazard_ra, 0);
    checkOutput("r5_wr_data", wr_data, 32'h5555_0002);

    // Simultaneous reserve and retire of r7 at count 1, then saturation at 3
    reserveReg(4'd7);
    query_sel_rc = 4'd7;
    rsv_en = 1'b1; rsv_sel = 4'd7;
    applyStimulus(0, 1'b1, 4'd7, 32'h7777_0000);
    tick();
    rsv_en = 1'b0;
    applyStimulus(0, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("r7_same_cycle_hazard", hazard_rc, 1);
    checkOutput("r7_same_cycle_wr_sel", wr_sel, 7);
    reserveReg(4'd7);
    reserveReg(4'd7);
    #1;
    checkOutput("r7_sat_rsv_ready", rsv_ready, 0);
    reserveReg(4'd7);
    #1;
    checkOutput("r7_sat_still_blocked", rsv_ready, 0);
    applyStimulus(0, 1'b1, 4'd7, 32'h7777_0001);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("r7_after_retire_ready", rsv_ready, 1);
    checkOutput("r7_after_retire_hazard", hazard_rc, 1);
    checkOutput("r7_no_err", err_underflow, 0);

    // Underflow: retire r9 with nothing pending
    applyStimulus(0, 1'b1, 4'd9, 32'h9999_9999);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("underflow_set", err_underflow, 1);
    checkOutput("underflow_wr_sel", wr_sel, 9);
    tick();
    checkOutput("underflow_sticky", err_underflow, 1);

    // Reset mid-traffic drops the in-flight write and all reservations
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'd7, 32'hFFFF_0000 + i);
    rsv_en = 1'b1; rsv_sel = 4'd6;
    tick();
    reset_n = 1'b0;
    tick();
    #1;
    checkOutput("midrst_wr_en", wr_en, 0);
    checkOutput("midrst_wr_sel", wr_sel, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    checkOutput("midrst_err", err_underflow, 0);
    checkOutput("midrst_req_ready", req_ready, 0);
    checkOutput("midrst_hazard", {hazard_ra, hazard_rb, hazard_rc}, 3'b000);
    req_valid = '0;
    rsv_en    = 1'b0;
    reset_n   = 1'b1;
    query_sel_ra = 4'd6;
    tick();
    checkOutput("post_midrst_r6", hazard_ra, 0);
    checkOutput("post_midrst_r7", hazard_rc, 0);
    rsv_sel = 4'd7;
    #1;
    checkOutput("post_midrst_rsv_ready", rsv_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
